// File: rtl/uart_operand_rx.sv
// rtl/uart_operand_rx.sv - 8N1 UART receiver that pairs good bytes into multiplier operands A and B
// A held A byte is abandoned after TIMEOUT_BITS idle bit-times; line breaks are parked until release.
module uart_operand_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW    = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LIMIT_C  = CW'(LIMIT);
  localparam logic [CW-1:0] EXPIRE_C = CW'(LIMIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d, rx_s_q, rx_s_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d, hold_q, hold_d;
  logic            good_q, good_d, ptr_q, ptr_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic            op_valid_q, op_valid_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic            drop;

  always_comb begin
    sync1_d     = rx_in;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    to_cnt_d    = to_cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    good_d      = 1'b0;
    drop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          timer_d   = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s_q) begin
            good_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            drop        = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pairing acts one cycle after the stop-bit sample; shift_q is untouched meanwhile.
    if (drop) begin
      ptr_d = 1'b0;
    end else if (good_q) begin
      if (!ptr_q) begin
        hold_d   = shift_q;
        ptr_d    = 1'b1;
        to_cnt_d = '0;
      end else begin
        op_a_d     = hold_q;
        op_b_d     = shift_q;
        op_valid_d = 1'b1;
        ptr_d      = 1'b0;
      end
    end else if (ptr_q && state_q == S_IDLE) begin
      if (to_cnt_q != LIMIT_C) to_cnt_d = to_cnt_q + CW'(1);
      if (to_cnt_q == EXPIRE_C) ptr_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE) || ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      good_q      <= 1'b0;
      ptr_q       <= 1'b0;
      to_cnt_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      good_q      <= good_d;
      ptr_q       <= ptr_d;
      to_cnt_q    <= to_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// tb/tb_uart_operand_rx.sv - directed and random frame stimulus against a pairing reference model
module tb_uart_operand_rx;
  localparam int CPB          = 16;
  localparam int TIMEOUT_CLKS = 32 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] op_a, op_b;
  logic       op_valid, frame_err, busy;

  uart_operand_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int ferr_obs = 0, ferr_exp = 0, both_cnt = 0, long_cnt = 0;
  logic prev_valid = 1'b0;
  bit         m_ptr_b;
  logic [7:0] m_hold;

  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid) obs_q.push_back({op_a, op_b});
      if (frame_err) ferr_obs++;
      if (op_valid && frame_err) both_cnt++;
      if (op_valid && prev_valid) long_cnt++;
    end
    prev_valid = op_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a good byte fills A then B; a bad stop or an idle gap past the timeout forgets A.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int gap);
    rx_in = 1'b1;
    tick(gap);
    if (m_ptr_b && gap > TIMEOUT_CLKS) m_ptr_b = 1'b0;
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    if (stop_ok) begin
      rx_in = 1'b1;
      tick(CPB);
      if (!m_ptr_b) begin
        m_hold  = b;
        m_ptr_b = 1'b1;
      end else begin
        exp_q.push_back({m_hold, b});
        m_ptr_b = 1'b0;
      end
    end else begin
      rx_in = 1'b0;
      tick(CPB + 40);
      rx_in = 1'b1;
      tick(2 * CPB);
      ferr_exp++;
      m_ptr_b = 1'b0;
    end
  endtask

  task automatic scoreboard(input string tag);
    int n;
    tick(40);
    check($sformatf("%s_pair_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pair%0d", tag, i), {16'h0, obs_q[i]}, {16'h0, exp_q[i]});
    check($sformatf("%s_frame_err_count", tag), ferr_obs, ferr_exp);
    obs_q.delete();
    exp_q.delete();
    ferr_obs = 0;
    ferr_exp = 0;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rok;
    int         rgap;

    rst     = 1'b1;
    rx_in   = 1'b1;
    m_ptr_b = 1'b0;
    m_hold  = '0;
    tick(4);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    send(8'h0C, 1'b1, 10);
    send(8'h0D, 1'b1, 0);
    scoreboard("t1");
    tick(100);
    check("t1_stable_a", op_a, 8'h0C);
    check("t1_stable_b", op_b, 8'h0D);

    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(10);
    check("t2_busy_idle", busy, 0);
    scoreboard("t2");

    send(8'h55, 1'b0, 20);
    send(8'h03, 1'b1, 0);
    send(8'h05, 1'b1, 0);
    scoreboard("t3");

    send(8'hAA, 1'b1, 10);
    send(8'h11, 1'b1, 600);
    send(8'h22, 1'b1, 0);
    scoreboard("t4");

    send(8'h01, 1'b1, 10);
    send(8'h02, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    send(8'hFE, 1'b1, 0);
    scoreboard("t5");

    send(8'h33, 1'b1, 10);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[0];
      tick(CPB);
    end
    tick(CPB / 2);
    rst   = 1'b1;
    rx_in = 1'b1;
    tick(3);
    check("t6_rst_op_a", op_a, 0);
    check("t6_rst_op_b", op_b, 0);
    check("t6_rst_op_valid", op_valid, 0);
    check("t6_rst_busy", busy, 0);
    rst     = 1'b0;
    m_ptr_b = 1'b0;
    tick(20);
    send(8'h07, 1'b1, 10);
    send(8'h09, 1'b1, 0);
    scoreboard("t6");
    check("t6_op_a", op_a, 8'h07);
    check("t6_op_b", op_b, 8'h09);

    for (int k = 0; k < 40; k++) begin
      rb   = 8'($urandom);
      rok  = ($urandom_range(0, 7) != 0);
      rgap = ($urandom_range(0, 3) == 0) ? 700 + int'($urandom_range(0, 200))
                                         : int'($urandom_range(0, 60));
      send(rb, rok, rgap);
    end
    scoreboard("rand");

    check("valid_and_ferr_overlap", both_cnt, 0);
    check("valid_pulse_width", long_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
